// File: rtl/pad_array_valve_sequencer_pkg.sv
// Shared types for the pad-array valve sequencer: FSM states, the program step
// record and the chain-settle length helper.
package pad_seq_pkg;

    localparam int STEP_CTRL_W  = 13;
    localparam int STEP_DWELL_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_FLUSH  = 3'd4
    } state_e;

    typedef struct packed {
        logic [STEP_CTRL_W-1:0]  ctrl;
        logic                    pump_en;
        logic [STEP_DWELL_W-1:0] dwell;
    } step_t;

    // Every chained device adds the same settle delay after a pattern change.
    function automatic int settle_len(input int size, input int per_dev);
        return size * per_dev;
    endfunction

endpackage

// File: rtl/pad_array_valve_sequencer_if.sv
// Host-side program/control bus plus pad-hole drives of the valve sequencer.
// start and prog_we are single-cycle strobes, accepted only while busy is low;
// there is no ready signal, busy is the only back-pressure the host sees.
interface pad_seq_if
    import pad_seq_pkg::*;
#(
    parameter int CTRL_W      = STEP_CTRL_W,
    parameter int PUMP_PHASES = 3,
    parameter int STEP_DEPTH  = 8,
    parameter int DWELL_W     = STEP_DWELL_W
);
    localparam int IDX_W = $clog2(STEP_DEPTH);

    logic                   prog_we;
    logic [IDX_W-1:0]       prog_addr;
    logic [CTRL_W-1:0]      prog_ctrl;
    logic                   prog_pump_en;
    logic [DWELL_W-1:0]     prog_dwell;
    logic [IDX_W:0]         num_steps;
    logic [7:0]             pump_div;
    logic                   start;
    logic                   abort;

    logic [CTRL_W-1:0]      ctrl_a;
    logic [PUMP_PHASES-1:0] pump_a;
    logic [CTRL_W-1:0]      flush_ctrl_a;
    logic [PUMP_PHASES-1:0] flush_pump_a;
    logic                   busy;
    logic                   done;
    logic [IDX_W-1:0]       step_idx;
    state_e                 dbg_state;

    modport master (
        output prog_we, prog_addr, prog_ctrl, prog_pump_en, prog_dwell,
        output num_steps, pump_div, start, abort,
        input  ctrl_a, pump_a, flush_ctrl_a, flush_pump_a, busy, done, step_idx, dbg_state
    );

    modport slave (
        input  prog_we, prog_addr, prog_ctrl, prog_pump_en, prog_dwell,
        input  num_steps, pump_div, start, abort,
        output ctrl_a, pump_a, flush_ctrl_a, flush_pump_a, busy, done, step_idx, dbg_state
    );

endinterface

// File: rtl/pad_array_valve_sequencer_phase_gen.sv
// Peristaltic pump pattern: all phases pressurised except one open bit that
// walks LSB->MSB once every div+1 enabled cycles.
module peristaltic_phase_gen #(
    parameter int PHASES = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clear,
    input  logic [7:0]        div,
    output logic [PHASES-1:0] phase
);
    localparam logic [PHASES-1:0] PHASE_INIT = ~PHASES'(1);

    logic [7:0]        div_cnt_q, div_cnt_d;
    logic [PHASES-1:0] phase_q, phase_d;

    // The divider idles at zero whenever disabled, so each enable window starts fresh.
    always_comb begin
        div_cnt_d = div_cnt_q;
        phase_d   = phase_q;
        if (clear) begin
            div_cnt_d = '0;
            phase_d   = PHASE_INIT;
        end else if (!en) begin
            div_cnt_d = '0;
        end else if (div_cnt_q >= div) begin
            div_cnt_d = '0;
            phase_d   = {phase_q[PHASES-2:0], phase_q[PHASES-1]};
        end else begin
            div_cnt_d = div_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            phase_q   <= PHASE_INIT;
        end else begin
            div_cnt_q <= div_cnt_d;
            phase_q   <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/pad_array_valve_sequencer.sv
// Step-program player for a serially chained pad array: loads a valve pattern,
// waits for the chain to settle, dwells with the pump rotating, then flushes.
module pad_array_valve_sequencer
    import pad_seq_pkg::*;
#(
    parameter int SIZE           = 7,
    parameter int SETTLE_PER_DEV = 4,
    parameter int CTRL_W         = STEP_CTRL_W,
    parameter int PUMP_PHASES    = 3,
    parameter int STEP_DEPTH     = 8,
    parameter int DWELL_W        = STEP_DWELL_W,
    parameter int FLUSH_CYCLES   = 64
) (
    input logic     clk,
    input logic     rst_n,
    pad_seq_if.slave bus
);
    localparam int IDX_W      = $clog2(STEP_DEPTH);
    localparam int NUM_W      = IDX_W + 1;
    localparam int SETTLE_LEN = settle_len(SIZE, SETTLE_PER_DEV);
    localparam int SETTLE_W   = $clog2(SETTLE_LEN + 1);
    localparam int FLUSH_W    = $clog2(FLUSH_CYCLES + 1);

    step_t mem_q [STEP_DEPTH];
    step_t cur;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       step_idx_q, step_idx_d;
    logic [NUM_W-1:0]       num_q, num_d;
    logic [SETTLE_W-1:0]    settle_q, settle_d;
    logic [DWELL_W-1:0]     dwell_q, dwell_d;
    logic [FLUSH_W-1:0]     flush_q, flush_d;
    logic [CTRL_W-1:0]      ctrl_a_q, ctrl_a_d;
    logic [CTRL_W-1:0]      flush_ctrl_a_q, flush_ctrl_a_d;
    logic [PUMP_PHASES-1:0] flush_pump_a_q, flush_pump_a_d;
    logic                   done_q, done_d;
    logic [PUMP_PHASES-1:0] phase;
    logic                   active;
    logic                   start_ok;

    // The running program is frozen: writes land only while idle.
    always_ff @(posedge clk) begin
        if (bus.prog_we && state_q == ST_IDLE) begin
            mem_q[bus.prog_addr] <= '{ctrl: bus.prog_ctrl, pump_en: bus.prog_pump_en, dwell: bus.prog_dwell};
        end
    end

    assign cur      = mem_q[step_idx_q];
    assign active   = (state_q == ST_LOAD) || (state_q == ST_SETTLE) || (state_q == ST_RUN);
    assign start_ok = bus.start && (bus.num_steps != '0) && (bus.num_steps <= NUM_W'(STEP_DEPTH));

    always_comb begin
        state_d    = state_q;
        step_idx_d = step_idx_q;
        num_d      = num_q;
        settle_d   = settle_q;
        dwell_d    = dwell_q;
        flush_d    = flush_q;
        ctrl_a_d   = ctrl_a_q;
        done_d     = 1'b0;
        if (bus.abort && active) begin
            state_d  = ST_FLUSH;
            flush_d  = FLUSH_W'(FLUSH_CYCLES - 1);
            ctrl_a_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_ok) begin
                        num_d      = bus.num_steps;
                        step_idx_d = '0;
                        state_d    = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    ctrl_a_d = cur.ctrl;
                    settle_d = SETTLE_W'(SETTLE_LEN - 1);
                    state_d  = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_q == '0) begin
                        // A zero dwell is stretched to one cycle.
                        dwell_d = (cur.dwell == '0) ? '0 : DWELL_W'(cur.dwell - 1'b1);
                        state_d = ST_RUN;
                    end else begin
                        settle_d = settle_q - 1'b1;
                    end
                end
                ST_RUN: begin
                    if (dwell_q != '0) begin
                        dwell_d = dwell_q - 1'b1;
                    end else if ({1'b0, step_idx_q} == num_q - 1'b1) begin
                        state_d  = ST_FLUSH;
                        flush_d  = FLUSH_W'(FLUSH_CYCLES - 1);
                        ctrl_a_d = '0;
                    end else begin
                        step_idx_d = step_idx_q + 1'b1;
                        state_d    = ST_LOAD;
                    end
                end
                ST_FLUSH: begin
                    if (flush_q == '0) begin
                        state_d    = ST_IDLE;
                        step_idx_d = '0;
                        done_d     = 1'b1;
                    end else begin
                        flush_d = flush_q - 1'b1;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    ctrl_a_d = '0;
                end
            endcase
        end
        flush_ctrl_a_d = (state_d == ST_FLUSH) ? '1 : '0;
        flush_pump_a_d = (state_d == ST_FLUSH) ? '1 : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            step_idx_q     <= '0;
            num_q          <= '0;
            settle_q       <= '0;
            dwell_q        <= '0;
            flush_q        <= '0;
            ctrl_a_q       <= '0;
            flush_ctrl_a_q <= '0;
            flush_pump_a_q <= '0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            step_idx_q     <= step_idx_d;
            num_q          <= num_d;
            settle_q       <= settle_d;
            dwell_q        <= dwell_d;
            flush_q        <= flush_d;
            ctrl_a_q       <= ctrl_a_d;
            flush_ctrl_a_q <= flush_ctrl_a_d;
            flush_pump_a_q <= flush_pump_a_d;
            done_q         <= done_d;
        end
    end

    // The phase pointer rests at its initial pattern through FLUSH so every run starts alike.
    peristaltic_phase_gen #(
        .PHASES (PUMP_PHASES)
    ) u_phase_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    ((state_q == ST_RUN) && cur.pump_en),
        .clear (state_q == ST_FLUSH),
        .div   (bus.pump_div),
        .phase (phase)
    );

    assign bus.ctrl_a       = ctrl_a_q;
    assign bus.pump_a       = active ? phase : '0;
    assign bus.flush_ctrl_a = flush_ctrl_a_q;
    assign bus.flush_pump_a = flush_pump_a_q;
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.done         = done_q;
    assign bus.step_idx     = step_idx_q;
    assign bus.dbg_state    = state_q;

endmodule

// File: doc/pad_array_valve_sequencer.md
Name: pad_array_valve_sequencer

Overview:
- Programmable pneumatic sequencer for a SIZE-device pad array whose control lines are serially chained device-to-device and terminate in flush holes.
- Plays a stored step program on the chained control lines ctrl_a and generates a rotating peristaltic pattern on pump_a.
- Waits a chain-settle time after every pattern change.
- Ends each run with a timed flush phase on the flush lines.
- Sits between the host register interface and the ctrl/flush pad holes.

Parameters:
- SIZE, 7, devices in the serial chain; settle time = SIZE*SETTLE_PER_DEV cycles.
- SETTLE_PER_DEV, 4, settle cycles per chained device (>=1).
- CTRL_W, 13, control-line count.
- PUMP_PHASES, 3, peristaltic pump phases (>=3).
- STEP_DEPTH, 8, program memory entries (power of 2).
- DWELL_W, 16, dwell counter width.
- FLUSH_CYCLES, 64, flush phase length (>=1).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- prog_we  in  1  write program entry; ignored while busy
- prog_addr  in  $clog2(STEP_DEPTH)  entry index
- prog_ctrl  in  CTRL_W  valve pattern for the step (1 = pressurised)
- prog_pump_en  in  1  pump rotates during the step
- prog_dwell  in  DWELL_W  step hold in cycles; 0 is treated as 1
- num_steps  in  $clog2(STEP_DEPTH)+1  steps to run; sampled at start
- pump_div  in  8  pump advances every pump_div+1 cycles
- start  in  1  single-cycle start request
- abort  in  1  jump to FLUSH
- ctrl_a  out  CTRL_W  chained control-line drive
- pump_a  out  PUMP_PHASES  pump drive
- flush_ctrl_a  out  CTRL_W  flush-hole vent for control lines
- flush_pump_a  out  PUMP_PHASES  flush-hole vent for pump lines
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on FLUSH->IDLE
- step_idx  out  $clog2(STEP_DEPTH)  current step

Behaviour:
- Reset (rst_n=0 at posedge):
  - State = IDLE; all outputs 0; counters 0.
  - Program memory is NOT cleared.
  - Reset mid-run closes all valves on the next edge, with no flush.
- IDLE:
  - start with num_steps in 1..STEP_DEPTH: latch num_steps, step_idx=0, go to LOAD.
  - start with num_steps=0 or >STEP_DEPTH: ignored.
- LOAD (1 cycle):
  - ctrl_a <= mem[step_idx].ctrl.
  - settle counter <= SIZE*SETTLE_PER_DEV-1.
  - Go to SETTLE.
- SETTLE:
  - Decrement the settle counter; pump is held.
  - At 0: dwell counter <= max(dwell,1)-1; go to RUN.
- RUN:
  - Decrement the dwell counter.
  - If pump_en, pump advances one phase each time the divider wraps. The divider resets on entry to RUN.
  - At 0 with more steps: step_idx+1, go to LOAD.
  - At 0 on the last step: go to FLUSH.
- Pump pattern:
  - All phases pressurised except one; the open (0) bit rotates LSB->MSB and wraps.
  - First pattern after reset or flush has bit0=0, e.g. 110 -> 101 -> 011 -> 110.
  - When pump_en=0, the last pattern is held.
- FLUSH:
  - ctrl_a=0, pump_a=0; flush_ctrl_a and flush_pump_a all 1.
  - Lasts FLUSH_CYCLES cycles, then IDLE with done=1 for one cycle.
  - Pump phase pointer resets to its initial value.
- abort:
  - From LOAD, SETTLE or RUN: go to FLUSH next cycle.
  - Ignored in IDLE and FLUSH; FLUSH is not restarted.
- Simultaneous events:
  - start and abort together in IDLE: start wins.
  - start during busy: ignored.
  - prog_we during busy: ignored; the running program is immutable.
- Outputs are registered; ctrl_a changes exactly one cycle after LOAD is entered.
- Flush lines are 0 in every state except FLUSH.
- Cycle counts: step time = 1 + SIZE*SETTLE_PER_DEV + max(dwell,1). Total run = sum of step times + FLUSH_CYCLES.

Decomposition:
- Package pad_seq_pkg holds:
  - the state enum (IDLE, LOAD, SETTLE, RUN, FLUSH);
  - the step_t struct {ctrl, pump_en, dwell};
  - a settle-length constant function.
- One sub-module, peristaltic_phase_gen: divider plus rotating one-open pattern, with ports en, clear, div, phase.
- Program memory is an inferred register array inside the top.

Test Plan:
1. Reset, then program step0 = {ctrl=0x1A5A, pump_en=0, dwell=5}, num_steps=1, start -> ctrl_a=0x1A5A after 1 cycle; busy held for 1+28+5+64=98 cycles; flush lines =1 for exactly 64 cycles; done pulse; all outputs 0 afterwards.
2. Single step with pump_en=1, pump_div=1, dwell=12 -> during RUN pump_a = 110,101,011,110,101,011, each held 2 cycles; pattern frozen during SETTLE.
3. num_steps=3 with dwell=0,1,2 -> both zero-dwell and one-dwell steps hold 1 cycle; step_idx goes 0,1,2; ctrl_a updates once per LOAD.
4. abort 10 cycles into SETTLE of step 1 -> FLUSH next cycle, 64 cycles, done; a second abort during FLUSH does not extend it.
5. rst_n=0 mid-RUN -> next edge all outputs 0, state IDLE, no done; restart after reset replays the retained program identically.
6. start with num_steps=0, or num_steps=9 (STEP_DEPTH=8) -> busy stays 0; prog_we during busy leaves the running ctrl values unchanged.
